fetch_queue_stage: RTL and testbench

- Parametrised successor to the single-register IF/ID boundary.
- Owns the PC and drives the instruction-memory address; same combinational read as instruction_mem.
- Buffers fetched {pc, instr, pc+4} entries in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- Supports decode back-pressure (stall) and branch/jump redirect (flush) without losing or duplicating instructions.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 35 +++
 rtl/fetch_queue_stage.sv | 73 +++++++
 tb/tb_fetch_queue_stage.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry type and count-width helper for the fetch queue stage
package fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FETCH_XLEN = 32;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc4;
  } fetch_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush, combinational head read and occupancy count
module fetch_fifo import fetch_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_data,
  output logic [WIDTH-1:0]          o_data,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_push);
      r_rptr  <= r_rptr + AW'(i_pop);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk)
    if (i_push && !rst && !i_flush) r_mem[r_wptr] <= i_data;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC owner and fetch queue feeding decode over valid/ready with redirect flush.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_stage import fetch_pkg::*; #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_pc4,
  output logic [cnt_w(DEPTH)-1:0]  q_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
`endif
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc4;
  } entry_t;
  logic [XLEN-1:0] r_pc, w_pc4;
  logic            w_pop, w_enq, w_full;
  entry_t          w_wr, w_head;
  assign w_pc4     = r_pc + XLEN'(4);
  assign w_full    = q_count == FULL;
  assign id_valid  = (q_count != '0) && !redirect_valid;
  assign w_pop     = id_valid && id_ready;
  assign w_enq     = !redirect_valid && (!w_full || w_pop);
  assign w_wr      = '{pc: r_pc, instr: imem_instr, pc4: w_pc4};
  assign imem_addr = r_pc;
  assign id_instr  = id_valid ? w_head.instr : NOP;
  assign id_pc     = id_valid ? w_head.pc : '0;
  assign id_pc4    = id_valid ? w_head.pc4 : '0;
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc & ~XLEN'(3);
    else if (w_enq) r_pc <= w_pc4;
  end
  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_data  (w_wr),
    .o_data  (w_head),
    .o_count (q_count)
  );
`ifdef FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_pop && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (w_full && !w_pop && !redirect_valid && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed checks of fetch queue ordering, stall, redirect, PC wrap and reset
module tb_fetch_queue_stage;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, id_instr, id_pc, id_pc4;
  logic        id_valid;
  logic [2:0]  q_count;
  logic [31:0] w_addr, w_instr, w_id_instr, w_id_pc, w_id_pc4;
  logic        w_id_valid;
  logic [2:0]  w_count;
  int n_cmp = 0;
  int n_err = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif
  always #5 clk = ~clk;
  assign imem_instr = imem_addr ^ 32'hA5;
  assign w_instr    = w_addr ^ 32'hA5;
  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc4(id_pc4), .q_count(q_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_instr(w_instr),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr),
    .id_pc(w_id_pc), .id_pc4(w_id_pc4), .q_count(w_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    step();
    chk("rst_count", 32'(q_count), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_instr", id_instr, 32'h13);
    chk("rst_pc", id_pc, 0);
    chk("rst_pc4", id_pc4, 0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
    reset = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_valid", 32'(id_valid), 1);
      chk("stream_pc", id_pc, 32'(4 * i));
      chk("stream_pc4", id_pc4, 32'(4 * i + 4));
      chk("stream_instr", id_instr, 32'(4 * i) ^ 32'hA5);
      chk("stream_count", 32'(q_count), 1);
      if (i < 3) begin
        chk("wrap_pc", w_id_pc, 32'hFFFF_FFF8 + 32'(4 * i));
        chk("wrap_pc4", w_id_pc4, 32'hFFFF_FFFC + 32'(4 * i));
      end
    end
    do_reset();
    id_ready = 1'b0;
    step(10);
    chk("full_count", 32'(q_count), 4);
    chk("full_addr", imem_addr, 32'h10);
    chk("full_head", id_pc, 0);
    id_ready = 1'b1;
    #1;
    chk("drain_pc0", id_pc, 0);
    step();
    chk("fullpop_count", 32'(q_count), 4);
    chk("fullpop_addr", imem_addr, 32'h14);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_pc", id_pc, 32'(4 * k));
      step();
    end
    do_reset();
    id_ready = 1'b0;
    step(3);
    chk("pre_redir_count", 32'(q_count), 3);
    redirect_valid = 1'b1; redirect_pc = 32'h103; id_ready = 1'b1;
    #1;
    chk("redir_valid", 32'(id_valid), 0);
    step();
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("post_redir_count", 32'(q_count), 0);
    chk("post_redir_addr", imem_addr, 32'h100);
    step();
    chk("redir_pc", id_pc, 32'h100);
    chk("redir_instr", id_instr, 32'h1A5);
    do_reset();
    id_ready = 1'b0;
    step(6);
    chk("pre_rst_count", 32'(q_count), 4);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_run", perf_stall, 2);
`endif
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("midrst_count", 32'(q_count), 0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_instr", id_instr, 32'h13);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_perf_fetched", perf_fetched, 0);
    chk("midrst_perf_stall", perf_stall, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
